// File: rtl/riscv_cache_evict_buffer.sv
// Single-entry write-back buffer: holds one dirty block and streams it to the BIU as a wrapping burst.
// Optional RV_CACHE_EVICT_FAST_STB_EN: strobe the BIU straight from the evict_* inputs while IDLE.
package riscv_cache_evict_buffer_pkg;
    typedef enum logic [2:0] {BYTE = 3'b000, HWORD, WORD, DWORD, QWORD} biu_size_t;
    typedef enum logic [2:0] {SINGLE = 3'b000, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16} biu_type_t;
    typedef logic [2:0] biu_prot_t;
endpackage

module riscv_cache_evict_buffer
    import riscv_cache_evict_buffer_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int PLEN       = XLEN,
    parameter int BLOCK_SIZE = XLEN,
    localparam int BLK_BITS  = 8 * BLOCK_SIZE
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                evict_req_i,
    output logic                evict_rdy_o,
    input  logic [PLEN-1:0]     evict_adr_i,
    input  logic [BLK_BITS-1:0] evict_dat_i,
    input  biu_prot_t           evict_prot_i,
    output logic                evict_done_o,
    output logic                evict_err_o,
    input  logic [PLEN-1:0]     lookup_adr_i,
    output logic                in_evictbuf_o,
    output logic [XLEN-1:0]     evictbuf_q_o,
    output logic                biu_stb_o,
    input  logic                biu_stb_ack_i,
    input  logic                biu_d_ack_i,
    output logic [PLEN-1:0]     biu_adri_o,
    output biu_size_t           biu_size_o,
    output biu_type_t           biu_type_o,
    output logic                biu_lock_o,
    output biu_prot_t           biu_prot_o,
    output logic                biu_we_o,
    output logic [XLEN-1:0]     biu_d_o,
    input  logic                biu_ack_i,
    input  logic                biu_err_i
);
    localparam int BURST_SIZE = BLK_BITS / XLEN;
    localparam int BURST_BITS = $clog2(BURST_SIZE);
    localparam int BLK_OFFS   = $clog2(BLOCK_SIZE);
    localparam int WOFFS      = $clog2(XLEN / 8);
    localparam logic [BURST_BITS-1:0] LAST = BURST_BITS'(BURST_SIZE - 1);
    localparam biu_type_t BURST_TYPE = (BURST_SIZE == 4) ? WRAP4 :
                                       (BURST_SIZE == 8) ? WRAP8 : WRAP16;

    typedef enum logic [1:0] {IDLE, WAIT4BIU, BURST} state_t;

    state_t                             state, state_d;
    logic                               valid;
    logic [PLEN-1:0]                    adr_q;
    logic [BURST_SIZE-1:0][XLEN-1:0]    dat_q;
    biu_prot_t                          prot_q;
    logic [BURST_BITS-1:0]              d_cnt, d_cnt_d, ack_cnt, ack_cnt_d;
    logic                               capture, clr_valid;
    logic                               unused_ok;

    assign unused_ok  = ^{evict_adr_i[BLK_OFFS-1:0], lookup_adr_i[WOFFS-1:0]};
    assign biu_size_o = (XLEN == 64) ? DWORD : WORD;
    assign biu_type_o = BURST_TYPE;
    assign biu_lock_o = 1'b0;

    // valid is only cleared on done/err, so lookups still hit in the done cycle
    assign in_evictbuf_o = valid & (lookup_adr_i[PLEN-1:BLK_OFFS] == adr_q[PLEN-1:BLK_OFFS]);
    assign evictbuf_q_o  = dat_q[lookup_adr_i[BLK_OFFS-1:WOFFS]];

    always_comb begin
        state_d      = state;
        d_cnt_d      = d_cnt;
        ack_cnt_d    = ack_cnt;
        capture      = 1'b0;
        clr_valid    = 1'b0;
        evict_rdy_o  = 1'b0;
        evict_done_o = 1'b0;
        evict_err_o  = 1'b0;
        biu_stb_o    = 1'b0;
        biu_we_o     = 1'b0;
        biu_adri_o   = adr_q;
        biu_d_o      = dat_q[d_cnt];
        biu_prot_o   = prot_q;
        unique case (state)
            IDLE: begin
                evict_rdy_o = 1'b1;
                if (evict_req_i) begin
                    capture = 1'b1;
                    state_d = WAIT4BIU;
                    d_cnt_d = '0;
                end
`ifdef RV_CACHE_EVICT_FAST_STB_EN
                biu_stb_o  = evict_req_i;
                biu_we_o   = evict_req_i;
                biu_adri_o = {evict_adr_i[PLEN-1:BLK_OFFS], {BLK_OFFS{1'b0}}};
                biu_d_o    = evict_dat_i[XLEN-1:0];
                biu_prot_o = evict_prot_i;
                if (evict_req_i && biu_stb_ack_i) begin
                    state_d   = BURST;
                    d_cnt_d   = {{(BURST_BITS-1){1'b0}}, biu_d_ack_i};
                    ack_cnt_d = LAST;
                end
`endif
            end
            WAIT4BIU: begin
                biu_stb_o = 1'b1;
                biu_we_o  = 1'b1;
                if (biu_stb_ack_i) begin
                    state_d   = BURST;
                    d_cnt_d   = {{(BURST_BITS-1){1'b0}}, biu_d_ack_i};
                    ack_cnt_d = LAST;
                end
            end
            BURST: begin
                biu_we_o = 1'b1;
                if (biu_d_ack_i && d_cnt != LAST) d_cnt_d = d_cnt + 1'b1;
                if (biu_ack_i) ack_cnt_d = ack_cnt - 1'b1;
                // error wins over a coincident final ack
                if (biu_err_i) begin
                    evict_err_o = 1'b1;
                    clr_valid   = 1'b1;
                    state_d     = IDLE;
                    d_cnt_d     = '0;
                    ack_cnt_d   = '0;
                end else if (biu_ack_i && ack_cnt == '0) begin
                    evict_done_o = 1'b1;
                    clr_valid    = 1'b1;
                    state_d      = IDLE;
                    d_cnt_d      = '0;
                    ack_cnt_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            valid   <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            prot_q  <= '0;
            d_cnt   <= '0;
            ack_cnt <= '0;
        end else begin
            state   <= state_d;
            d_cnt   <= d_cnt_d;
            ack_cnt <= ack_cnt_d;
            if (capture) begin
                valid  <= 1'b1;
                adr_q  <= {evict_adr_i[PLEN-1:BLK_OFFS], {BLK_OFFS{1'b0}}};
                dat_q  <= evict_dat_i;
                prot_q <= evict_prot_i;
            end else if (clr_valid) begin
                valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_riscv_cache_evict_buffer.sv
// Scoreboard bench for riscv_cache_evict_buffer (XLEN=32, 32-byte blocks, WRAP8 bursts).
module tb_riscv_cache_evict_buffer;
    import riscv_cache_evict_buffer_pkg::*;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              evict_req_i, evict_rdy_o, evict_done_o, evict_err_o;
    logic [31:0]       evict_adr_i, lookup_adr_i, biu_adri_o, biu_d_o, evictbuf_q_o;
    logic [255:0]      evict_dat_i;
    biu_prot_t         evict_prot_i, biu_prot_o;
    logic              in_evictbuf_o, biu_stb_o, biu_stb_ack_i, biu_d_ack_i;
    biu_size_t         biu_size_o;
    biu_type_t         biu_type_o;
    logic              biu_lock_o, biu_we_o, biu_ack_i, biu_err_i;

    int                n_vec = 0, n_err = 0;
    logic [31:0]       sb[$];
    bit                lk_on = 0, lk_hit = 0, done_seen = 0;
    logic [31:0]       lk_q = '0;

    always #5 clk_i = ~clk_i;

    riscv_cache_evict_buffer #(.XLEN(32), .PLEN(32), .BLOCK_SIZE(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .evict_req_i(evict_req_i), .evict_rdy_o(evict_rdy_o), .evict_adr_i(evict_adr_i),
        .evict_dat_i(evict_dat_i), .evict_prot_i(evict_prot_i),
        .evict_done_o(evict_done_o), .evict_err_o(evict_err_o),
        .lookup_adr_i(lookup_adr_i), .in_evictbuf_o(in_evictbuf_o), .evictbuf_q_o(evictbuf_q_o),
        .biu_stb_o(biu_stb_o), .biu_stb_ack_i(biu_stb_ack_i), .biu_d_ack_i(biu_d_ack_i),
        .biu_adri_o(biu_adri_o), .biu_size_o(biu_size_o), .biu_type_o(biu_type_o),
        .biu_lock_o(biu_lock_o), .biu_prot_o(biu_prot_o), .biu_we_o(biu_we_o),
        .biu_d_o(biu_d_o), .biu_ack_i(biu_ack_i), .biu_err_i(biu_err_i)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic drive_block(input logic [31:0] adr, input logic [31:0] base);
        evict_req_i  = 1'b1;
        evict_adr_i  = adr;
        evict_prot_i = biu_prot_t'(adr[30:28]);
        for (int i = 0; i < 8; i++) begin
            evict_dat_i[i*32 +: 32] = base + 32'(i);
            sb.push_back(base + 32'(i));
        end
    endtask

    // entered at posedge+1 with the buffer idle
    task automatic evict(input logic [31:0] adr, input logic [31:0] base);
        drive_block(adr, base);
        #3;
        chk("rdy_at_req", evict_rdy_o, 1'b1);
        @(posedge clk_i); #1;
        evict_req_i = 1'b0;
    endtask

    // BIU responder; stop_at > 0 abandons the burst after that many acks
    task automatic biu_run(input logic [31:0] exp_adr, input int stb_wait, input bit dack_stb,
                           input int ack_lag, input int err_at, input int stop_at);
        int  wcnt = 0, bcyc = 0, dacks = 0, acks = 0, cyc = 0;
        bit  burst = 0, fin = 0, go = 0, d, a, e;
        while (!fin && cyc < 300) begin
            d = 0; a = 0; e = 0; go = 0;
            biu_stb_ack_i = 1'b0;
            if (!burst) begin
                if (biu_stb_o) begin
                    if (wcnt == stb_wait) begin
                        biu_stb_ack_i = 1'b1;
                        d  = dack_stb;
                        go = 1;
                        chk("adri", biu_adri_o, exp_adr);
                        chk("stb_we", biu_we_o, 1'b1);
                        chk("prot", biu_prot_o, exp_adr[30:28]);
                        chk("type", biu_type_o, WRAP8);
                        chk("size", biu_size_o, WORD);
                        chk("lock", biu_lock_o, 1'b0);
                    end
                    wcnt++;
                end
            end else begin
                bcyc++;
                d = (dacks < 8);
                if (bcyc >= ack_lag && acks < 8) begin
                    if (acks == err_at) e = 1; else a = 1;
                end
            end
            biu_d_ack_i = d; biu_ack_i = a; biu_err_i = e;
            #3;
            if (d) begin
                if (sb.size() == 0) chk("sb_empty", 1'b1, 1'b0);
                else chk("data", biu_d_o, sb.pop_front());
            end
            chk("done", evict_done_o, a && acks == 7);
            chk("err", evict_err_o, e);
            if (burst) begin
                chk("burst_stb", biu_stb_o, 1'b0);
                chk("burst_we", biu_we_o, 1'b1);
                if (lk_on) begin
                    chk("lk_hit", in_evictbuf_o, lk_hit);
                    if (lk_hit) chk("lk_q", evictbuf_q_o, lk_q);
                end
            end
            @(posedge clk_i); #1;
            biu_stb_ack_i = 1'b0; biu_d_ack_i = 1'b0; biu_ack_i = 1'b0; biu_err_i = 1'b0;
            if (d) dacks++;
            if (a) acks++;
            if (go) burst = 1;
            if ((a && acks == 8) || e) begin
                fin = 1;
                done_seen = a;
                chk("rdy_after", evict_rdy_o, 1'b1);
                if (lk_on) chk("lk_after", in_evictbuf_o, 1'b0);
            end
            if (stop_at > 0 && acks == stop_at) fin = 1;
            cyc++;
        end
        if (!fin) chk("burst_timeout", 1'b0, 1'b1);
    endtask

    task automatic hold_req(input logic [31:0] adr, input logic [31:0] base);
        int n = 0;
        drive_block(adr, base);
        forever begin
            #3;
            if (evict_rdy_o) break;
            n++;
            if (n > 100) begin chk("bp_timeout", 1'b0, 1'b1); break; end
            @(posedge clk_i); #1;
        end
        chk("bp_blocked", n > 0, 1'b1);
        chk("bp_after_done", done_seen, 1'b1);
        @(posedge clk_i); #1;
        evict_req_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0; evict_req_i = 1'b0; evict_adr_i = '0; evict_dat_i = '0; evict_prot_i = '0;
        lookup_adr_i = '0; biu_stb_ack_i = 1'b0; biu_d_ack_i = 1'b0; biu_ack_i = 1'b0; biu_err_i = 1'b0;
        #3;
        chk("rst_rdy", evict_rdy_o, 1'b1);
        chk("rst_stb", biu_stb_o, 1'b0);
        chk("rst_we", biu_we_o, 1'b0);
        chk("rst_pulses", {evict_done_o, evict_err_o}, 2'b00);
        chk("rst_adri", biu_adri_o, 32'h0);
        chk("rst_d", biu_d_o, 32'h0);
        chk("rst_hit", in_evictbuf_o, 1'b0);
        @(posedge clk_i); #1; rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // basic write-back with in-burst lookup hit
        lookup_adr_i = 32'h1000_0058; lk_on = 1; lk_hit = 1; lk_q = 32'hA6;
        evict(32'h1000_0044, 32'hA0);
        biu_run(32'h1000_0040, 2, 1, 1, -1, 0);

        // decoupled acks, lookup one block past the buffer misses
        lookup_adr_i = 32'h1000_0060; lk_hit = 0;
        evict(32'h1000_0044, 32'hB0);
        biu_run(32'h1000_0040, 0, 1, 4, -1, 0);

        // first data beat not consumed with the strobe ack
        lookup_adr_i = 32'h2000_0000; lk_hit = 1; lk_q = 32'hC0;
        evict(32'h2000_001C, 32'hC0);
        biu_run(32'h2000_0000, 1, 0, 2, -1, 0);

        // error on beat 3
        lookup_adr_i = 32'h3000_0014; lk_q = 32'hD5;
        evict(32'h3000_0010, 32'hD0);
        biu_run(32'h3000_0000, 0, 1, 1, 3, 0);
        sb.delete();

        // back-pressure: second block held until the first completes
        lk_on = 0; done_seen = 0;
        evict(32'h4000_0000, 32'hE0);
        fork
            biu_run(32'h4000_0000, 1, 1, 1, -1, 0);
            hold_req(32'h5000_0024, 32'hF0);
        join
        biu_run(32'h5000_0020, 0, 1, 1, -1, 0);

        // async reset in the middle of the burst
        lookup_adr_i = 32'h6000_0008; lk_on = 1; lk_hit = 1; lk_q = 32'h62;
        evict(32'h6000_0000, 32'h60);
        biu_run(32'h6000_0000, 0, 1, 1, -1, 5);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_rdy", evict_rdy_o, 1'b1);
        chk("mid_rst_stb_we", {biu_stb_o, biu_we_o}, 2'b00);
        chk("mid_rst_pulses", {evict_done_o, evict_err_o}, 2'b00);
        chk("mid_rst_hit", in_evictbuf_o, 1'b0);
        chk("mid_rst_d", biu_d_o, 32'h0);
        chk("mid_rst_adri", biu_adri_o, 32'h0);
        @(posedge clk_i); #1; rst_ni = 1'b1;
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("post_rst_quiet", {evict_done_o, evict_err_o, biu_stb_o}, 3'b000);
            @(posedge clk_i); #1;
        end

        lookup_adr_i = 32'h7000_000C; lk_q = 32'h73;
        evict(32'h7000_0000, 32'h70);
        biu_run(32'h7000_0000, 1, 1, 1, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/riscv_cache_evict_buffer.md
Name: riscv_cache_evict_buffer

Overview:
- Single-entry write-back (eviction) buffer between the cache memory FSM and the BIU, on the write side of the cache BIU path.
- Captures one dirty block, along with its block address and protection bits.
- Streams the block to the BIU as one wrapping write burst, then reports completion or error to the memory FSM.
- While the write-back is pending, read requests that hit the evicted block are served from the buffer.

Parameters:
- XLEN, 32, data bus width in bits (32 or 64)
- PLEN, XLEN, physical address width
- BLOCK_SIZE, XLEN, cache block size in bytes; BLK_BITS = 8*BLOCK_SIZE, BURST_SIZE = BLK_BITS/XLEN (4, 8 or 16)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- evict_req_i  in  1  memory FSM presents a dirty block
- evict_rdy_o  out  1  buffer empty, can accept
- evict_adr_i  in  PLEN  block address; offset bits ignored
- evict_dat_i  in  BLK_BITS  block data, word 0 at LSBs
- evict_prot_i  in  biu_prot_t  protection bits
- evict_done_o  out  1  one-cycle pulse: burst completed
- evict_err_o  out  1  one-cycle pulse: burst terminated by error
- lookup_adr_i  in  PLEN  read address to check against buffer
- in_evictbuf_o  out  1  lookup hits the buffered block
- evictbuf_q_o  out  XLEN  word addressed by lookup_adr_i
- biu_stb_o  out  1  access request
- biu_stb_ack_i  in  1  request accepted
- biu_d_ack_i  in  1  BIU consumed biu_d_o
- biu_adri_o  out  PLEN  burst start address
- biu_size_o  out  biu_size_t  WORD (XLEN=32) / DWORD (XLEN=64)
- biu_type_o  out  biu_type_t  WRAP4/WRAP8/WRAP16 per BURST_SIZE
- biu_lock_o  out  1  tied 0
- biu_prot_o  out  biu_prot_t  latched prot
- biu_we_o  out  1  write enable
- biu_d_o  out  XLEN  write data
- biu_ack_i  in  1  beat acknowledge
- biu_err_i  in  1  transfer error

Behaviour:
- Clock and reset: one clock, clk_i, rising edge; asynchronous active-low reset rst_ni.
- Reset values:
  - state = IDLE, valid = 0.
  - evict_rdy_o = 1.
  - All pulses, biu_stb_o and biu_we_o = 0; counters = 0.
  - biu_d_o/adri_o drive held registers (x-free, 0 after reset).
- State machine:
  - IDLE: evict_rdy_o = 1. On evict_req_i, latch block address (offset bits cleared), data and prot; set valid; go to WAIT4BIU.
  - WAIT4BIU:
    - biu_stb_o = 1, biu_we_o = 1, biu_adri_o = latched address, biu_d_o = word 0.
    - Strobe is held until biu_stb_ack_i; then go to BURST with d_cnt = 1 if biu_d_ack_i was also high that cycle, else d_cnt = 0.
  - BURST:
    - biu_stb_o = 0, biu_we_o = 1, biu_d_o = word[d_cnt].
    - biu_d_ack_i increments d_cnt, saturating at BURST_SIZE-1.
    - biu_ack_i decrements ack_cnt (loaded with BURST_SIZE-1 on entry).
    - biu_ack_i while ack_cnt == 0: evict_done_o pulses that cycle (combinational), clear valid, go to IDLE.
    - biu_err_i in any cycle: evict_err_o pulses, clear valid, go to IDLE. Remaining beats are dropped.
- biu_d_ack_i and biu_ack_i are independent: several data beats may be consumed before the first ack.
- In IDLE, biu_d_ack_i and biu_ack_i are ignored.
- biu_type_o / biu_size_o are constant from parameters.
- Lookup is combinational:
  - in_evictbuf_o = valid & (lookup_adr_i[PLEN-1:BLK_OFFS] == latched address tag).
  - evictbuf_q_o = word[lookup_adr_i offset].
  - valid stays high until done/err, so lookups hit during the whole write-back, including the cycle evict_done_o pulses.
- Back-to-back: a new evict_req_i is accepted the cycle after evict_done_o, when evict_rdy_o = 1 again.
- evict_req_i while not ready: ignored. The requester must hold it.
- Reset mid-burst: the buffer is emptied and no done/err pulse is issued.

Optional Feature:
- Macro RV_CACHE_EVICT_FAST_STB_EN.
- Defined: in IDLE, biu_stb_o = evict_req_i combinationally, with biu_adri_o/biu_d_o/biu_prot_o driven from the evict_* inputs.
  - Capture happens on the same edge.
  - If biu_stb_ack_i is high in that cycle, go directly to BURST (d_cnt rules as in WAIT4BIU); otherwise go to WAIT4BIU.
  - Saves one cycle of latency.
- Undefined: strobe is first asserted the cycle after capture, as described in Behaviour.

Test Plan (XLEN=32, BLOCK_SIZE=32, 8 beats, WRAP8):
- Basic write-back: evict adr 0x1000_0044, dat words 0..7 = 0xA0..0xA7; stb_ack after 2 cycles; d_ack/ack each cycle. Expect biu_adri_o = 0x1000_0040, biu_d_o sequence 0xA0..0xA7, biu_we_o = 1, type WRAP8, one evict_done_o on the 8th ack, evict_rdy_o = 1 the next cycle.
- Lookup: during the burst, lookup 0x1000_0058 -> in_evictbuf_o = 1, evictbuf_q_o = 0xA6. Lookup 0x1000_0060 -> in_evictbuf_o = 0. After done, the same 0x1000_0058 lookup -> 0.
- Decoupled acks: 4 d_acks back-to-back, then acks trail by 3 cycles. Expect correct data order and done only on the 8th ack.
- Error: biu_err_i on beat 3 -> evict_err_o pulses once, no done, state IDLE, in_evictbuf_o = 0.
- Back-pressure: evict_req_i held while busy -> not accepted until the cycle after done. The second block's address appears on the next strobe.
- Async reset during BURST beat 5 -> all outputs at reset values immediately, no pulses. A new eviction afterwards completes normally.
